// File: rtl/pwm_dither_gen.sv
// PWM generator with a programmable prescaler and a 16-slot dither pattern that
// adds one extra high step to selected periods. Settings take effect only at period wrap.
module pwm_dither_gen #(
    parameter int CCW = 24
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [CCW-1:0] cfg_i,
    input  logic [31:0]    freq_div_i,
    input  logic           dith_en_i,
    output logic           pwm_o,
    output logic           sync_o,
    output logic [3:0]     idx_o
);

    logic [31:0] pre_q,   pre_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [3:0]  idx_q,   idx_d;
    logic [7:0]  duty_q,  duty_d;
    logic [15:0] mask_q,  mask_d;
    logic        dith_q,  dith_d;
    logic [31:0] divl_q,  divl_d;
    logic        pwm_q,   pwm_d;
    logic        sync_q,  sync_d;

    logic       tick;
    logic       wrap;
    logic [8:0] thr;

    // Threshold derives purely from settings latched at wrap, so it cannot
    // change mid-period regardless of what the inputs do.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        tick   = (pre_q == divl_q - 32'd1);
        wrap   = tick && (cnt_q == 8'hFF);
        thr    = {1'b0, duty_q} + {8'b0, dith_q & mask_q[idx_q]};

        pre_d  = tick ? 32'd0 : pre_q + 32'd1;
        cnt_d  = tick ? cnt_q + 8'd1 : cnt_q;
        idx_d  = idx_q;
        duty_d = duty_q;
        mask_d = mask_q;
        dith_d = dith_q;
        divl_d = divl_q;

        if (wrap) begin
            idx_d  = idx_q + 4'd1;
            duty_d = cfg_i[CCW-1:CCW-8];
            mask_d = cfg_i[15:0];
            dith_d = dith_en_i;
            divl_d = (freq_div_i == 32'd0) ? 32'd1 : freq_div_i;
        end

        pwm_d  = ({1'b0, cnt_q} < thr);
        sync_d = wrap;
    end

    // Reset values make the first edge after release a wrap (pre=0 matches divl-1=0, cnt=255).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_q  <= 32'd0;
            cnt_q  <= 8'hFF;
            idx_q  <= 4'hF;
            duty_q <= 8'd0;
            mask_q <= 16'd0;
            dith_q <= 1'b0;
            divl_q <= 32'd1;
            pwm_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            duty_q <= duty_d;
            mask_q <= mask_d;
            dith_q <= dith_d;
            divl_q <= divl_d;
            pwm_q  <= pwm_d;
            sync_q <= sync_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign sync_o = sync_q;
    assign idx_o  = idx_q;

endmodule
